// File: rtl/wb_local_arb_pkg.sv
// rtl/wb_local_arb_pkg.sv - shared state encoding and widths for the local-bus arbiter
package wb_local_arb_pkg;

  localparam int MAX_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 8;
  localparam int IDX_W   = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

endpackage

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - round-robin picker, search starts at the port after last_idx
module wb_rr_pick
  import wb_local_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               valid,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [MAX_REQ-1:0] req_ext;
  logic [IDX_W-1:0]   cand;

  assign req_ext = MAX_REQ'(req);

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    valid     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(last_idx) + off) % NUM_REQ);
      if (req_ext[cand]) begin
        valid     = 1'b1;
        grant_idx = cand;
      end
    end
  end

endmodule

// File: rtl/wb_local_arbiter.sv
// rtl/wb_local_arbiter.sv - round-robin arbiter of NUM_REQ requesters onto one local command port
// Optional watchdog in WAIT enabled by WB_LOCAL_ARB_TIMEOUT_EN.
module wb_local_arbiter
  import wb_local_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [NUM_REQ*8-1:0]    req_addr,
  input  logic [NUM_REQ*8-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_W-1:0]       address,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    wr_en,
  output logic                    rd_en,
  input  logic                    xfer_done,
  input  logic                    xfer_req,
  input  logic [DATA_W-1:0]       rd_data
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               wr_en_q, wr_en_d;
  logic               rd_en_q, rd_en_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [MAX_REQ-1:0] we_ext;
  logic [MAX_REQ-1:0] win_onehot;
  logic [ADDR_W-1:0]  addr_arr  [MAX_REQ];
  logic [DATA_W-1:0]  wdata_arr [MAX_REQ];

  assign we_ext     = MAX_REQ'(req_we);
  assign win_onehot = MAX_REQ'(1) << win_q;

  for (genvar g = 0; g < MAX_REQ; g++) begin : g_unpack
    if (g < NUM_REQ) begin : g_port
      assign addr_arr[g]  = req_addr[g*8 +: 8];
      assign wdata_arr[g] = req_wdata[g*8 +: 8];
    end else begin : g_pad
      assign addr_arr[g]  = '0;
      assign wdata_arr[g] = '0;
    end
  end

  wb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (req_valid),
    .last_idx  (last_q),
    .valid     (pick_valid),
    .grant_idx (pick_idx)
  );

`ifdef WB_LOCAL_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       err_q, err_d;
  logic       timeout;

  assign timeout = (wd_cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign rsp_err = err_q;

  always_comb begin
    wd_cnt_d = '0;
    if (state_q == WAIT) wd_cnt_d = wd_cnt_q + 8'd1;
    err_d = err_q;
    if (state_q == WAIT) begin
      if (xfer_done)    err_d = 1'b0;
      else if (timeout) err_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid && xfer_req) begin
          state_d = ISSUE;
          win_d   = pick_idx;
          last_d  = pick_idx;
          we_d    = we_ext[pick_idx];
          addr_d  = addr_arr[pick_idx];
          wdata_d = wdata_arr[pick_idx];
          wr_en_d = we_ext[pick_idx];
          rd_en_d = !we_ext[pick_idx];
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Completion outranks a watchdog expiry landing in the same cycle.
        if (xfer_done) begin
          state_d = RESP;
          rdata_d = we_q ? '0 : rd_data;
        end
`ifdef WB_LOCAL_ARB_TIMEOUT_EN
        else if (timeout) begin
          state_d = RESP;
          rdata_d = '0;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
    end
  end

  assign address   = addr_q;
  assign wr_data   = wdata_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign rsp_rdata = rdata_q;
  assign req_ready = (state_q == ISSUE) ? NUM_REQ'(win_onehot) : '0;
  assign rsp_valid = (state_q == RESP)  ? NUM_REQ'(win_onehot) : '0;

endmodule

// File: tb/tb_wb_local_arbiter.sv
// tb/tb_wb_local_arbiter.sv - directed table-driven bench for wb_local_arbiter
module tb_wb_local_arbiter;

  localparam int NUM_REQ = 2;

  logic                 wb_clk_i = 1'b0;
  logic                 wb_rst_i = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_we = '0;
  logic [NUM_REQ*8-1:0] req_addr = '0;
  logic [NUM_REQ*8-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_rdata;
  logic                 rsp_err;
  logic [7:0]           address;
  logic [7:0]           wr_data;
  logic                 wr_en;
  logic                 rd_en;
  logic                 xfer_done = 1'b0;
  logic                 xfer_req = 1'b1;
  logic [7:0]           rd_data = '0;

  int n_vec  = 0;
  int n_miss = 0;

  wb_local_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .address  (address), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
    .xfer_done(xfer_done), .xfer_req(xfer_req), .rd_data(rd_data)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    int         port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd_data;
    int         delay;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [4];

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
    req_valid[p]         = 1'b1;
    req_we[p]            = we;
    req_addr[p*8 +: 8]   = a;
    req_wdata[p*8 +: 8]  = d;
  endtask

  task automatic wait_ready(output int cycles, output logic ok);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      step();
      cycles++;
      if (req_ready != '0) ok = 1'b1;
    end
  endtask

  task automatic wait_rsp(output int cycles, output logic ok);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      cycles++;
      if (rsp_valid != '0) ok = 1'b1;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {8'(req_ready), 8'(rsp_valid), rsp_rdata, rsp_err, wr_en, rd_en, 5'd0} ^
           {address, wr_data, 16'd0};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic ok;
    logic extra;
    vec_t v;

    vecs[0] = '{0, 1'b1, 8'h12, 8'hA5, 8'h00, 3, 8'h00};
    vecs[1] = '{1, 1'b0, 8'h40, 8'h00, 8'h3C, 1, 8'h3C};
    vecs[2] = '{1, 1'b1, 8'hFF, 8'h00, 8'h77, 2, 8'h00};
    vecs[3] = '{0, 1'b0, 8'h00, 8'h9E, 8'hC3, 5, 8'hC3};

    step();
    step();
    check("reset_outputs", all_outs(), 32'h0);
    check("reset_addr_data", {address, wr_data}, 16'h0);
    wb_rst_i = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      set_req(v.port, v.we, v.addr, v.wdata);
      wait_ready(cyc, ok);
      check("ready_seen", ok, 1);
      check("ready_latency", cyc, 1);
      check("ready_onehot", req_ready, 1 << v.port);
      check("enables", {wr_en, rd_en}, v.we ? 2'b10 : 2'b01);
      check("address", address, v.addr);
      check("wr_data", wr_data, v.wdata);
      req_valid[v.port] = 1'b0;
      extra = 1'b0;
      for (int d = 0; d < v.delay; d++) begin
        step();
        extra |= wr_en | rd_en | (|req_ready) | (|rsp_valid);
      end
      xfer_done = 1'b1;
      rd_data   = v.rd_data;
      step();
      xfer_done = 1'b0;
      rd_data   = 8'h00;
      check("single_pulse", extra, 0);
      check("rsp_valid", rsp_valid, 1 << v.port);
      check("rsp_rdata", rsp_rdata, v.exp_rdata);
      check("rsp_err", rsp_err, 0);
      check("address_hold", address, v.addr);
      step();
      check("rsp_pulse_end", rsp_valid, 0);
    end

    // Contention from a fresh reset: port 0 first, then alternate.
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0;
    set_req(0, 1'b1, 8'h10, 8'h01);
    set_req(1, 1'b1, 8'h20, 8'h02);
    for (int t = 0; t < 4; t++) begin
      wait_ready(cyc, ok);
      check("cont_ready_seen", ok, 1);
      check("cont_grant", req_ready, (t % 2 == 0) ? 2'b01 : 2'b10);
      check("cont_address", address, (t % 2 == 0) ? 8'h10 : 8'h20);
      step();
      check("cont_ready_once", req_ready, 0);
      xfer_done = 1'b1;
      step();
      xfer_done = 1'b0;
      check("cont_rsp", rsp_valid, (t % 2 == 0) ? 2'b01 : 2'b10);
    end
    req_valid = '0;
    step();
    step();

    // Downstream busy: nothing issues until the cycle after xfer_req rises.
    xfer_req = 1'b0;
    set_req(0, 1'b1, 8'h55, 8'h66);
    extra = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      extra |= wr_en | rd_en | (|req_ready);
    end
    check("busy_no_issue", extra, 0);
    xfer_req = 1'b1;
    step();
    check("busy_release_wr_en", {wr_en, req_ready}, 3'b101);
    req_valid = '0;
    step();
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    check("busy_rsp", rsp_valid, 2'b01);
    step();

    // Reset while waiting drops the transfer; late done is ignored; port 0 regains priority.
    set_req(0, 1'b0, 8'h33, 8'h00);
    wait_ready(cyc, ok);
    check("rstwait_grant0", req_ready, 2'b01);
    req_valid = '0;
    step();
    step();
    wb_rst_i = 1'b1;
    step();
    check("rstwait_outputs", all_outs(), 32'h0);
    wb_rst_i  = 1'b0;
    xfer_done = 1'b1;
    rd_data   = 8'hAB;
    step();
    xfer_done = 1'b0;
    rd_data   = 8'h00;
    extra = (|rsp_valid);
    for (int c = 0; c < 5; c++) begin
      step();
      extra |= (|rsp_valid) | wr_en | rd_en;
    end
    check("rstwait_no_rsp", extra, 0);
    set_req(0, 1'b1, 8'h44, 8'h11);
    set_req(1, 1'b1, 8'h88, 8'h22);
    wait_ready(cyc, ok);
    check("rstwait_port0_first", req_ready, 2'b01);
    req_valid = '0;
    step();
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    step();

`ifdef WB_LOCAL_ARB_TIMEOUT_EN
    set_req(0, 1'b0, 8'h70, 8'h00);
    wait_ready(cyc, ok);
    req_valid = '0;
    rd_data   = 8'hEE;
    wait_rsp(cyc, ok);
    rd_data   = 8'h00;
    check("to_rsp_seen", ok, 1);
    check("to_latency", cyc, 9);
    check("to_rsp_valid", rsp_valid, 2'b01);
    check("to_err", rsp_err, 1);
    check("to_rdata", rsp_rdata, 0);
    step();
    set_req(1, 1'b0, 8'h71, 8'h00);
    wait_ready(cyc, ok);
    req_valid = '0;
    extra = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      extra |= (|rsp_valid);
    end
    xfer_done = 1'b1;
    rd_data   = 8'h5A;
    step();
    xfer_done = 1'b0;
    rd_data   = 8'h00;
    check("to_edge_no_early", extra, 0);
    check("to_edge_rsp", rsp_valid, 2'b10);
    check("to_edge_err", rsp_err, 0);
    check("to_edge_rdata", rsp_rdata, 8'h5A);
    step();
`else
    set_req(0, 1'b0, 8'h70, 8'h00);
    wait_ready(cyc, ok);
    req_valid = '0;
    wait_rsp(cyc, ok);
    check("no_to_no_rsp", ok, 0);
    check("no_to_err", rsp_err, 0);
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
